keypad_scanner: RTL and testbench

- Drives the 4x4 keypad matrix: walks a one-cold pattern on `keypad_row`, samples `keypad_col`, and decodes the pressed key to a hex code.
- Debounces across full scan frames. Emits a one-cycle `key_valid` strobe per debounced press, plus a held level.
- Supplies the game logic (mole hit detection) and the seven-segment display with a clean key code, replacing passive sampling of the matrix.

---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_debounce.sv | 116 +++++++++++
 rtl/keypad_scanner.sv | 84 ++++++++
 tb/tb_keypad_scanner.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, types and key map for the 4x4 keypad scanner.
package keypad_pkg;

  localparam logic [3:0] ROW_0 = 4'b0111;
  localparam logic [3:0] ROW_1 = 4'b1011;
  localparam logic [3:0] ROW_2 = 4'b1101;
  localparam logic [3:0] ROW_3 = 4'b1110;

  typedef enum logic [1:0] {IDLE, PRESS_CNT, HELD, RELEASE_CNT} db_state_t;
  typedef enum logic [1:0] {NONE, KEY, MULTI} frame_res_t;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = ROW_0;
      2'd1:    r = ROW_1;
      2'd2:    r = ROW_2;
      default: r = ROW_3;
    endcase
    return r;
  endfunction

  // col_idx 0 is the column sensed on bit 3 (pattern 0111).
  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0: code = 4'hf;
      4'h1: code = 4'he;
      4'h2: code = 4'hd;
      4'h3: code = 4'hc;
      4'h4: code = 4'hb;
      4'h5: code = 4'h3;
      4'h6: code = 4'h6;
      4'h7: code = 4'h9;
      4'h8: code = 4'ha;
      4'h9: code = 4'h2;
      4'ha: code = 4'h5;
      4'hb: code = 4'h8;
      4'hc: code = 4'h0;
      4'hd: code = 4'h1;
      4'he: code = 4'h4;
      default: code = 4'h7;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix drive/sense plus the debounced key outputs.
interface keypad_scanner_if;
  logic [3:0] keypad_row;
  logic [3:0] keypad_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (output keypad_row, key_code, key_valid, key_held, input keypad_col);
  modport slave  (input keypad_row, key_code, key_valid, key_held, output keypad_col);
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: accepts a key after DEBOUNCE_FRAMES matching frames.
// Outputs update on the edge after frame_done; no backpressure, key_valid is a one-cycle strobe.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_done,
  input  frame_res_t res_type,
  input  logic [3:0] res_code,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  db_state_t  state, state_nxt;
  logic [3:0] cand, cand_nxt, cnt, cnt_nxt, code_nxt, cnt_inc;
  logic       valid_nxt, held_nxt, do_accept, is_key, hit_cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    held_nxt  = key_held;
    do_accept = 1'b0;
    is_key    = (res_type == KEY);
    hit_cand  = is_key && (res_code == cand);
    cnt_inc   = cnt + 4'd1;

    if (frame_done) begin
      case (state)
        IDLE: begin
          if (is_key) begin
            cand_nxt = res_code;
            if (DF == 4'd1) begin
              do_accept = 1'b1;
            end else begin
              state_nxt = PRESS_CNT;
              cnt_nxt   = 4'd1;
            end
          end
        end
        PRESS_CNT: begin
          if (hit_cand) begin
            if (cnt_inc >= DF) do_accept = 1'b1;
            else               cnt_nxt   = cnt_inc;
          end else if (is_key) begin
            cand_nxt = res_code;
            cnt_nxt  = 4'd1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        HELD: begin
          if (!hit_cand) begin
            if (DF == 4'd1) begin
              state_nxt = IDLE;
              held_nxt  = 1'b0;
            end else begin
              state_nxt = RELEASE_CNT;
              cnt_nxt   = 4'd1;
            end
          end
        end
        RELEASE_CNT: begin
          if (hit_cand) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt_inc >= DF) begin
            state_nxt = IDLE;
            held_nxt  = 1'b0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // cand_nxt already holds the code being accepted on the IDLE path.
    if (do_accept) begin
      state_nxt = HELD;
      code_nxt  = cand_nxt;
      valid_nxt = 1'b1;
      held_nxt  = 1'b1;
      cnt_nxt   = '0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-cold row walk, per-frame column collection, debounced key code out.
// Latency DEBOUNCE_FRAMES frames + 1 cycle from a stable frame start; no backpressure.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 250000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  logic [3:0]  col_meta, col_sync;
  logic [31:0] div_cnt;
  logic [1:0]  row_idx, col_idx;
  logic        row_end, frame_done;
  logic        frame_any, frame_multi, any_nxt, multi_nxt;
  logic [3:0]  frame_code, code_nxt;
  logic [2:0]  n_low;
  frame_res_t  res_type;

  assign row_end       = (div_cnt == 32'(SCAN_DIV - 1));
  assign frame_done    = row_end && (row_idx == 2'd3);
  assign kp.keypad_row = row_drive(row_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta    <= 4'hf;
      col_sync    <= 4'hf;
      div_cnt     <= '0;
      row_idx     <= '0;
      frame_any   <= 1'b0;
      frame_multi <= 1'b0;
      frame_code  <= '0;
    end else begin
      col_meta <= kp.keypad_col;
      col_sync <= col_meta;
      if (row_end) begin
        div_cnt <= '0;
        row_idx <= row_idx + 2'd1;
        if (frame_done) begin
          frame_any   <= 1'b0;
          frame_multi <= 1'b0;
          frame_code  <= '0;
        end else begin
          frame_any   <= any_nxt;
          frame_multi <= multi_nxt;
          frame_code  <= code_nxt;
        end
      end else begin
        div_cnt <= div_cnt + 32'd1;
      end
    end
  end

  // Fold the current row's sample into the frame; on the last row this is the frame result.
  always_comb begin
    n_low   = '0;
    col_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!col_sync[i]) begin
        n_low   = n_low + 3'd1;
        col_idx = 2'(3 - i);
      end
    end
    any_nxt   = frame_any || (n_low != 3'd0);
    multi_nxt = frame_multi || (n_low > 3'd1) || ((n_low != 3'd0) && frame_any);
    code_nxt  = ((n_low != 3'd0) && !frame_any) ? key_map(row_idx, col_idx) : frame_code;
    res_type  = multi_nxt ? MULTI : (any_nxt ? KEY : NONE);
  end

  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .res_type   (res_type),
    .res_code   (code_nxt),
    .key_code   (kp.key_code),
    .key_valid  (kp.key_valid),
    .key_held   (kp.key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner: a matrix model, directed key sequences, strobe monitor.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DF    = 3;
  localparam int FRAME = 4 * SD;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  col_model;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 1;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  // {row index, col index} of each key code on the matrix.
  function automatic logic [3:0] key_pos(input int k);
    logic [3:0] p;
    case (k)
      0:  p = 4'b11_00;
      1:  p = 4'b11_01;
      2:  p = 4'b10_01;
      3:  p = 4'b01_01;
      4:  p = 4'b11_10;
      5:  p = 4'b10_10;
      6:  p = 4'b01_10;
      7:  p = 4'b11_11;
      8:  p = 4'b10_11;
      9:  p = 4'b01_11;
      10: p = 4'b10_00;
      11: p = 4'b01_00;
      12: p = 4'b00_11;
      13: p = 4'b00_10;
      14: p = 4'b00_01;
      default: p = 4'b00_00;
    endcase
    return p;
  endfunction

  function automatic int row_bit(input int k);
    logic [3:0] p;
    p = key_pos(k);
    return 3 - int'(p[3:2]);
  endfunction

  function automatic int col_bit(input int k);
    logic [3:0] p;
    p = key_pos(k);
    return 3 - int'(p[1:0]);
  endfunction

  function automatic logic [3:0] row_exp(input int c);
    logic [3:0] r;
    r = 4'b1000 >> (((c - 1) / SD) % 4);
    return ~r;
  endfunction

  always_comb begin
    col_model = 4'hf;
    for (int k = 0; k < 16; k++) begin
      if (pressed[k] && (kp.keypad_row[row_bit(k)] == 1'b0)) col_model[col_bit(k)] = 1'b0;
    end
  end
  assign kp.keypad_col = col_model;

  always @(posedge clk) begin
    if (rst) cyc <= 1;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input logic [3:0] code, input int frame);
    exp_t e;
    e.code = code;
    e.cyc  = frame * FRAME + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe code %0h at cycle %0d, no strobe expected", kp.key_code, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_code", 32'(kp.key_code), 32'(e.code));
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_held", 32'(kp.key_held), 32'd1);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_row", 32'(kp.keypad_row), 32'h7);
    check("reset_code", 32'(kp.key_code), 32'h0);
    check("reset_valid", 32'(kp.key_valid), 32'h0);
    check("reset_held", 32'(kp.key_held), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      check("row_seq", 32'(kp.keypad_row), 32'(row_exp(cyc)));
    end
    @(posedge clk);
    #1;

    // clean press of 5 from frame 3; release from frame 8
    pressed[5] = 1'b1;
    expect_strobe(4'h5, 5);
    frames(2);
    check("press_pending_held", 32'(kp.key_held), 32'd0);
    frames(1);
    check("press_held", 32'(kp.key_held), 32'd1);
    check("press_code", 32'(kp.key_code), 32'h5);
    frames(2);
    pressed = '0;
    frames(2);
    check("release_pending_held", 32'(kp.key_held), 32'd1);
    frames(1);
    check("release_held_clear", 32'(kp.key_held), 32'd0);
    check("release_code_kept", 32'(kp.key_code), 32'h5);

    // bounce on e: frames 11,12 on, 13 off, 14..16 on
    pressed[14] = 1'b1;
    frames(2);
    pressed = '0;
    frames(1);
    pressed[14] = 1'b1;
    expect_strobe(4'he, 16);
    frames(3);
    check("bounce_code", 32'(kp.key_code), 32'he);
    pressed = '0;
    frames(3);

    // 1 and 9 together, then 9 released
    pressed[1] = 1'b1;
    pressed[9] = 1'b1;
    frames(5);
    check("multi_no_held", 32'(kp.key_held), 32'd0);
    check("multi_code_kept", 32'(kp.key_code), 32'he);
    pressed[9] = 1'b0;
    expect_strobe(4'h1, 27);
    frames(3);
    pressed = '0;
    frames(3);

    // 7 accepted, then switched straight to c
    pressed[7] = 1'b1;
    expect_strobe(4'h7, 33);
    frames(4);
    pressed    = '0;
    pressed[12] = 1'b1;
    expect_strobe(4'hc, 40);
    frames(3);
    check("change_released", 32'(kp.key_held), 32'd0);
    check("change_code_kept", 32'(kp.key_code), 32'h7);
    frames(3);
    check("change_code_new", 32'(kp.key_code), 32'hc);
    check("change_held", 32'(kp.key_held), 32'd1);
    pressed = '0;
    frames(3);

    // reset while a is two frames into debounce
    pressed[10] = 1'b1;
    frames(2);
    repeat (FRAME / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_held", 32'(kp.key_held), 32'd0);
    check("rst_mid_row", 32'(kp.keypad_row), 32'h7);
    check("rst_mid_code", 32'(kp.key_code), 32'h0);
    rst = 1'b0;
    expect_strobe(4'ha, 3);
    frames(2);
    check("rst_pending_held", 32'(kp.key_held), 32'd0);
    frames(1);
    check("rst_after_held", 32'(kp.key_held), 32'd1);
    check("rst_after_code", 32'(kp.key_code), 32'ha);
    frames(1);

    check("strobes_outstanding", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
